ram_port_arbiter: RTL and testbench

//  Shares the single 10-bit command port of the 256x8 single-port RAM between two requesters
//  (req0 = SPI slave, req1 = host/debug).

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_port_arbiter_rr_arb2.sv | 18 +
 rtl/ram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM state encoding for the RAM command-port arbiter.
package ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK    = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one that did not go last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM command port between two requesters, keeping 00/01 and 10/11 pairs atomic.
// Optional lock watchdog is enabled by defining ARB_TIMEOUT_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [ADDR_SIZE+1:0] req0_din,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_SIZE+1:0] req1_din,
    output logic                 req1_ready,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic [1:0]           err,
    output state_t               dbg_state
);

    state_t               state;
    logic                 owner;
    logic                 rr_last;
    logic [1:0]           arb_grant;
    logic [1:0]           grant;
    logic                 accept;
    logic                 winner;
    logic [ADDR_SIZE+1:0] cmd;
    logic [1:0]           op;
    logic [1:0]           err_q;
    logic                 wd_expired;

    rr_arb2 u_rr_arb2 (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .grant   (arb_grant)
    );

    // Handshake: readyN is high only in a cycle where commandN is taken (validN & grant),
    // so readyN itself is the accept strobe; at most one ready is ever high.
    always_comb begin
        grant = 2'b00;
        case (state)
            IDLE:    grant = arb_grant;
            LOCK:    grant = owner ? {req1_valid, 1'b0} : {1'b0, req0_valid};
            default: grant = 2'b00;
        endcase
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign winner     = grant[1];
    assign cmd        = winner ? req1_din : req0_din;
    assign op         = cmd[ADDR_SIZE+1 -: 2];
    assign dbg_state  = state;
    assign err        = err_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wd_cnt;

    assign wd_expired = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles of the current lock/read; restarts whenever the owner moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE || accept) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            rr_last      <= 1'b1;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_data     <= '0;
            err_q        <= 2'b00;
        end else begin
            ram_rx_valid <= accept;
            if (accept) begin
                ram_din <= cmd;
            end
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            err_q      <= 2'b00;

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_WR_DATA: rr_last <= winner;
                            OP_RD_DATA: begin
                                owner <= winner;
                                state <= RD_WAIT;
                            end
                            default: begin
                                owner <= winner;
                                state <= LOCK;
                            end
                        endcase
                    end
                end
                LOCK: begin
                    if (accept) begin
                        case (op)
                            OP_WR_DATA: begin
                                rr_last <= owner;
                                state   <= IDLE;
                            end
                            OP_RD_DATA: state <= RD_WAIT;
                            default:    state <= LOCK;
                        endcase
                    end else if (wd_expired) begin
                        err_q   <= owner ? 2'b10 : 2'b01;
                        rr_last <= owner;
                        state   <= IDLE;
                    end
                end
                RD_WAIT: begin
                    // tx_valid is sticky in the RAM, but the 10 of this read cleared it.
                    if (ram_tx_valid) begin
                        rsp_data   <= ram_dout;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        rr_last    <= owner;
                        state      <= IDLE;
                    end else if (wd_expired) begin
                        err_q   <= owner ? 2'b10 : 2'b01;
                        rr_last <= owner;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences and randomized traffic
// checked by a transaction-level model of the port and the RAM behind it.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_din = '0, req1_din = '0;
    logic       req0_ready, req1_ready, ram_rx_valid, rsp0_valid, rsp1_valid;
    logic [9:0] ram_din;
    logic [7:0] ram_dout, rsp_data;
    logic       ram_tx_valid;
    logic [1:0] err;
    state_t     dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_SIZE(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .err(err), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM behind the port: not reset by rst_n, tx_valid sticky until the next 10.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_addr = '0;
    bit         ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'hC3;
            ram_init     <= 1'b1;
            ram_tx_valid <= 1'b0;
            ram_dout     <= '0;
        end else if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: ram_addr <= ram_din[7:0];
                2'b01: ram_mem[ram_addr] <= ram_din[7:0];
                2'b10: begin ram_addr <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                default: begin ram_dout <= ram_mem[ram_addr]; ram_tx_valid <= 1'b1; end
            endcase
        end
    end

    // Reference model: who may use the port, transaction-level memory, fixed 3-cycle read reply.
    int         m_holder;
    bit         m_last;
    int         m_rd_left;
    bit         m_rd_req;
    logic [7:0] m_rd_data;
    logic [7:0] m_port_addr = '0;
    logic [7:0] ref_mem [256];
    bit         ref_init = 1'b0;
    bit         p_acc;
    logic [9:0] p_cmd;
    bit         mon_en = 1'b0;

    always @(negedge clk) begin
        int  w;
        bit  rsp_due;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            m_holder = -1; m_last = 1'b1; m_rd_left = 0; p_acc = 1'b0;
        end else if (mon_en) begin
            check("ram_rx_valid", ram_rx_valid, p_acc);
            if (p_acc) check("ram_din", ram_din, p_cmd);
            rsp_due = 1'b0;
            if (m_rd_left > 0) begin
                m_rd_left--;
                rsp_due = (m_rd_left == 0);
            end
            check("rsp0_valid", rsp0_valid, rsp_due && !m_rd_req);
            check("rsp1_valid", rsp1_valid, rsp_due && m_rd_req);
            if (rsp_due) check("rsp_data", rsp_data, m_rd_data);
            check("err_idle", err, 2'b00);
            w = -1;
            if (m_rd_left == 0) begin
                if (m_holder >= 0) begin
                    if (m_holder == 0 ? req0_valid : req1_valid) w = m_holder;
                end else if (req0_valid && req1_valid) w = m_last ? 0 : 1;
                else if (req0_valid) w = 0;
                else if (req1_valid) w = 1;
            end
            check("model_req0_ready", req0_ready, w == 0);
            check("model_req1_ready", req1_ready, w == 1);
            p_acc = (w >= 0);
            if (p_acc) begin
                p_cmd = (w == 1) ? req1_din : req0_din;
                case (p_cmd[9:8])
                    2'b01: begin
                        ref_mem[m_port_addr] = p_cmd[7:0];
                        m_holder = -1; m_last = (w == 1);
                    end
                    2'b11: begin
                        m_rd_data = ref_mem[m_port_addr]; m_rd_req = (w == 1);
                        m_rd_left = 3; m_holder = -1; m_last = (w == 1);
                    end
                    default: begin
                        m_port_addr = p_cmd[7:0]; m_holder = w;
                    end
                endcase
            end
        end
    end

    typedef struct {
        logic       v0;
        logic [9:0] d0;
        logic       v1;
        logic [9:0] d1;
        logic       r0, r1, s0, s1;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic v0, input logic [9:0] d0, input logic v1,
                                input logic [9:0] d1, input logic r0, input logic r1,
                                input logic s0, input logic s1, input logic [7:0] data);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1; v.data = data;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [9:0] d0, input logic v1, input logic [9:0] d1);
        req0_valid = v0; req0_din = d0; req1_valid = v1; req1_din = d1;
    endtask

    // Call at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step_expect(input string name, input logic r0, input logic r1);
        @(negedge clk);
        check({name, "_ready0"}, req0_ready, r0);
        check({name, "_ready1"}, req1_ready, r1);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int r, input logic [9:0] c);
        bit ok;
        ok = 1'b0;
        if (r == 0) begin req0_valid = 1'b1; req0_din = c; end
        else begin req1_valid = 1'b1; req1_din = c; end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (r == 0 ? req0_ready : req1_ready) begin ok = 1'b1; break; end
        end
        check("beat_accepted", ok, 1'b1);
        @(posedge clk); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_traffic(input int r, input int n_tx);
        for (int t = 0; t < n_tx; t++) begin
            int         kind;
            logic [7:0] a, d;
            kind = $urandom_range(0, 2);
            a = 8'h80 | 8'($urandom_range(0, 15));
            d = 8'($urandom);
            case (kind)
                0: begin send_beat(r, {2'b00, a}); gap($urandom_range(0, 2)); send_beat(r, {2'b01, d}); end
                1: begin send_beat(r, {2'b10, a}); gap($urandom_range(0, 2)); send_beat(r, {2'b11, 8'h00}); end
                default: send_beat(r, {2'b01, d});
            endcase
            gap($urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_din", ram_din, 10'h000);
        check("rst_ram_rx_valid", ram_rx_valid, 1'b0);
        check("rst_rsp0", rsp0_valid, 1'b0);
        check("rst_rsp1", rsp1_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_err", err, 2'b00);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Contention, write/read by req0, single-beat 01 by req1, re-targeted read
        tbl.push_back(mk(1, 10'h030, 1, 10'h031, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h111, 1, 10'h031, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h012, 1, 10'h031, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h012, 1, 10'h122, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h012, 0, 10'h000, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h1A5, 0, 10'h000, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h212, 0, 10'h000, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h300, 0, 10'h000, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h177, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h177, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h177, 0, 1, 1, 0, 8'hA5));
        tbl.push_back(mk(1, 10'h020, 1, 10'h060, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h220, 1, 10'h060, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 10'h300, 1, 10'h060, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h060, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h060, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 1, 10'h060, 0, 1, 1, 0, 8'hE3));
        tbl.push_back(mk(0, 10'h000, 1, 10'h144, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_ready0", i), req0_ready, tbl[i].r0);
            check($sformatf("vec%0d_ready1", i), req1_ready, tbl[i].r1);
            check($sformatf("vec%0d_rsp0", i), rsp0_valid, tbl[i].s0);
            check($sformatf("vec%0d_rsp1", i), rsp1_valid, tbl[i].s1);
            if (tbl[i].s0 || tbl[i].s1) check($sformatf("vec%0d_data", i), rsp_data, tbl[i].data);
            @(posedge clk); #1;
        end

        // Lock hold: req1 stalls for the whole read transaction of req0
        drive(1, 10'h240, 1, 10'h070);
        step_expect("lock_addr", 1, 0);
        drive(0, 10'h000, 1, 10'h070);
        for (int i = 0; i < 5; i++) step_expect("lock_hold", 0, 0);
        drive(1, 10'h300, 1, 10'h070);
        step_expect("lock_rd", 1, 0);
        drive(0, 10'h000, 1, 10'h070);
        step_expect("lock_wait1", 0, 0);
        step_expect("lock_wait2", 0, 0);
        @(negedge clk);
        check("lock_rsp0", rsp0_valid, 1'b1);
        check("lock_rsp_data", rsp_data, 8'h83);
        check("lock_req1_granted", req1_ready, 1'b1);
        @(posedge clk); #1;
        drive(0, 10'h000, 1, 10'h155);
        step_expect("lock_req1_data", 0, 1);
        drive(0, 10'h000, 0, 10'h000);

        // Async reset while a read is outstanding
        drive(1, 10'h250, 0, 10'h000);
        step_expect("rst_rd_addr", 1, 0);
        drive(1, 10'h300, 0, 10'h000);
        step_expect("rst_rd_data", 1, 0);
        drive(0, 10'h000, 0, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ram_rx_valid", ram_rx_valid, 1'b0);
        check("arst_ram_din", ram_din, 10'h000);
        check("arst_rsp_data", rsp_data, 8'h00);
        check("arst_rsp0", rsp0_valid, 1'b0);
        check("arst_state", dbg_state, IDLE);
        check("arst_err", err, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            @(posedge clk); #1;
        end
        drive(1, 10'h051, 1, 10'h052);
        step_expect("arst_tie", 1, 0);
        drive(1, 10'h166, 1, 10'h052);
        step_expect("arst_req0_data", 1, 0);
        drive(0, 10'h000, 1, 10'h052);
        step_expect("arst_req1_addr", 0, 1);
        drive(0, 10'h000, 1, 10'h177);
        step_expect("arst_req1_data", 0, 1);
        drive(0, 10'h000, 0, 10'h000);

        // Randomized traffic from both requesters
        fork
            rand_traffic(0, 40);
            rand_traffic(1, 40);
        join
        repeat (5) @(posedge clk);
        #1;

`ifdef ARB_TIMEOUT_EN
        // Watchdog abort of an abandoned write lock
        mon_en = 1'b0;
        drive(0, 10'h000, 1, 10'h003);
        step_expect("wd_addr", 0, 1);
        drive(0, 10'h000, 0, 10'h000);
        begin
            int k;
            k = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (err != 2'b00) begin k = n; break; end
            end
            check("wd_err_value", err, 2'b10);
            check("wd_err_cycle", k, 9);
            @(negedge clk);
            check("wd_err_pulse", err, 2'b00);
        end
        @(posedge clk); #1;
        drive(1, 10'h004, 1, 10'h005);
        step_expect("wd_after", 1, 0);
        drive(1, 10'h1AA, 1, 10'h005);
        step_expect("wd_after_data", 1, 0);
        drive(0, 10'h000, 0, 10'h000);
        repeat (3) @(posedge clk);
        #1;
        check("wd_no_write", ram_mem[3], 8'hC0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
